fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
Write-side controller for the RGB frame buffer. It accepts a pixel stream over a valid/ready handshake, with a start-of-frame marker on the first pixel of each frame. Accepted pixels pass through a small FIFO and are written into the frame memory in raster order, addresses 0 to H_RES*V_RES-1. Memory writes are permitted only while wr_gate is high (typically during blanking), and the FIFO absorbs the stalls.

Parameters:
DATA_WIDTH, 8, width of one pixel (RGB bits)
H_RES, 640, pixels per line
V_RES, 480, lines per frame
ADDR_WIDTH, 19, frame memory address width; must satisfy 2^ADDR_WIDTH >= H_RES*V_RES
FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
s_valid  input  1  upstream pixel valid
s_ready  output  1  pixel accepted on an edge where s_valid & s_ready
s_data  input  DATA_WIDTH  pixel value
s_sof  input  1  marks first pixel of a frame; qualified by s_valid
wr_gate  input  1  1 = memory writes permitted this cycle
mem_we  output  1  frame memory write enable
mem_addr  output  ADDR_WIDTH  frame memory write address
mem_wdata  output  DATA_WIDTH  frame memory write data
frame_done  output  1  one-cycle pulse, coincident with the write of address H_RES*V_RES-1
sof_err  output  1  one-cycle pulse on a premature SOF
busy  output  1  high while in state LOCKED

Behaviour:
- Reset is asynchronous, active-low; clock is clk. During and after reset:
  - FIFO empty; state SYNC; internal write address 0.
  - s_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, frame_done=0, sof_err=0, busy=0.
  - Reset asserted mid-frame drops all FIFO contents and any partial frame.
- FIFO:
  - Each entry holds {sof, data}.
  - s_ready = !full. The decision is combinational from the FIFO count only; it does not depend on s_valid.
  - Push happens when s_valid & s_ready.
  - Simultaneous push and pop: both occur and the count is unchanged.
  - When full, no push occurs even if a pop happens in the same cycle.
- Pop condition: FIFO not empty AND (wr_gate OR the head entry is to be discarded).
- State machine (SYNC, LOCKED), evaluated on each pop:
  - SYNC, head sof=0: entry discarded; no write; wr_gate ignored; state stays SYNC.
  - SYNC, head sof=1: write to address 0; next address 1; go to LOCKED.
  - LOCKED, head sof=0: write to current address; address increments.
  - LOCKED, head sof=1 with address != 0: sof_err pulse; entry written to address 0; next address 1; stay LOCKED.
  - LOCKED, any write to address H_RES*V_RES-1: frame_done pulse; address returns to 0; go to SYNC. The next frame must begin with an SOF pixel.
- Output timing:
  - mem_we, mem_addr, mem_wdata, frame_done and sof_err are registered. They are valid in the cycle after the pop edge.
  - mem_we=1 for exactly one cycle per write.
  - mem_addr and mem_wdata hold their last values when mem_we=0.
- Latency: the pixel accepted at edge N is written with mem_we high after edge N+1 (minimum). It is later if wr_gate is low or earlier entries are pending.
- wr_gate low in LOCKED: no pops; FIFO fills, then s_ready drops. No data is lost.
- Address arithmetic is ADDR_WIDTH bits and never exceeds H_RES*V_RES-1.

Test Plan:
- Reset state: hold rst_n=0 with s_valid=1 -> s_ready=1, mem_we=0, busy=0, all outputs 0. Release reset -> still 0 until a pixel is accepted.
- Full frame, reduced sizing (H_RES=4, V_RES=2, wr_gate=1): 8 pixels 0x10..0x17, SOF on the first -> writes at addr 0..7 with data 0x10..0x17, one per cycle. frame_done pulses with the addr 7 write; busy falls afterwards.
- Pre-sync discard: 3 pixels with sof=0, then an SOF pixel 0xAA -> no mem_we for the first three. 0xAA is written to addr 0 and busy rises.
- Backpressure: after SOF, wr_gate=0 while 6 pixels are offered -> s_ready drops after 4 accepts (FIFO_DEPTH=4). On wr_gate=1, all pixels are written in order with no gaps or loss.
- Premature SOF: SOF, then 2 pixels, then SOF pixel 0x55 -> sof_err pulses once, 0x55 is written to addr 0, and the next pixel goes to addr 1.
- Reset mid-frame: assert rst_n=0 after 3 writes -> outputs clear immediately and FIFO is empty. The next frame starts from SOF at addr 0.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: buffers a valid/ready pixel stream and writes whole frames into frame memory in raster order.
module fb_pixel_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_WIDTH = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_sof,
    input  logic                  wr_gate,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  frame_done,
    output logic                  sof_err,
    output logic                  busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(H_RES * V_RES - 1);
    typedef enum logic {SYNC, LOCKED} state_t;
    state_t state;
    logic [DATA_WIDTH:0] fifo [FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH-1:0] addr, wa;
    logic [DATA_WIDTH-1:0] head_data;
    logic head_sof, full, empty, push, pop, discard, last, premature;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign s_ready = !full;
    assign push = s_valid && s_ready;
    assign {head_sof, head_data} = fifo[rd_ptr[PW-1:0]];
    // Before sync, non-SOF pixels are dropped regardless of wr_gate so the FIFO never stalls on junk.
    assign discard = (state == SYNC) && !head_sof;
    assign pop = !empty && (wr_gate || discard);
    assign wa = head_sof ? '0 : addr;
    assign last = wa == LAST;
    assign premature = (state == LOCKED) && head_sof && (addr != '0);
    assign busy = state == LOCKED;
    always_ff @(posedge clk)
        if (push) fifo[wr_ptr[PW-1:0]] <= {s_sof, s_data};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            state      <= SYNC;
            addr       <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            mem_we     <= pop && !discard;
            frame_done <= pop && !discard && last;
            sof_err    <= pop && premature;
            if (pop && !discard) begin
                mem_addr  <= wa;
                mem_wdata <= head_data;
                addr      <= last ? '0 : wa + 1'b1;
                state     <= last ? SYNC : LOCKED;
            end
        end
endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: directed checks of fb_pixel_writer with a 4x2 frame and a 4-entry FIFO.
module tb_fb_pixel_writer;
    logic clk = 0, rst_n = 0, s_valid = 0, s_sof = 0, wr_gate = 0;
    logic [7:0] s_data = 0;
    logic s_ready, mem_we, frame_done, sof_err, busy;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata;
    int checks = 0, failures = 0, cyc = 0, errs = 0, dones = 0;
    logic [2:0] la[$];
    logic [7:0] ld[$];
    int lc[$];
    logic lf[$], le[$];

    fb_pixel_writer #(.DATA_WIDTH(8), .H_RES(4), .V_RES(2), .ADDR_WIDTH(3), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .wr_gate(wr_gate), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .frame_done(frame_done), .sof_err(sof_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mem_we) begin
            la.push_back(mem_addr);
            ld.push_back(mem_wdata);
            lc.push_back(cyc);
            lf.push_back(frame_done);
            le.push_back(sof_err);
        end
        if (sof_err) errs++;
        if (frame_done) dones++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        la.delete(); ld.delete(); lc.delete(); lf.delete(); le.delete();
        errs = 0; dones = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic sof, input logic [7:0] d);
        int n = 0;
        logic ok = 0;
        s_valid = 1; s_sof = sof; s_data = d;
        do begin
            @(negedge clk); ok = s_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 50);
        s_valid = 0; s_sof = 0;
        chk("send_accept", {31'd0, ok}, 1);
    endtask

    task automatic chk_wr(input int i, input logic [2:0] a, input logic [7:0] d);
        chk($sformatf("wr%0d_addr", i), {29'd0, la[i]}, {29'd0, a});
        chk($sformatf("wr%0d_data", i), {24'd0, ld[i]}, {24'd0, d});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        // Reset state with s_valid high
        s_valid = 1;
        tick(3);
        chk("rst_s_ready", {31'd0, s_ready}, 1);
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_mem_addr", {29'd0, mem_addr}, 0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 0);
        chk("rst_frame_done", {31'd0, frame_done}, 0);
        chk("rst_sof_err", {31'd0, sof_err}, 0);
        s_valid = 0; rst_n = 1;
        tick(2);
        chk("post_rst_mem_we", {31'd0, mem_we}, 0);
        chk("post_rst_busy", {31'd0, busy}, 0);

        // Full frame, one pixel per cycle, one-cycle latency
        clear_log();
        wr_gate = 1;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1; s_sof = (i == 0); s_data = 8'h10 + 8'(i);
            @(posedge clk); #1;
            if (i > 0) begin
                chk("ff_we", {31'd0, mem_we}, 1);
                chk("ff_addr", {29'd0, mem_addr}, 32'(i - 1));
                chk("ff_data", {24'd0, mem_wdata}, 32'h10 + 32'(i - 1));
                chk("ff_busy", {31'd0, busy}, 1);
                chk("ff_done_low", {31'd0, frame_done}, 0);
            end
        end
        s_valid = 0; s_sof = 0;
        @(posedge clk); #1;
        chk("ff_last_we", {31'd0, mem_we}, 1);
        chk("ff_last_addr", {29'd0, mem_addr}, 7);
        chk("ff_last_data", {24'd0, mem_wdata}, 8'h17);
        chk("ff_frame_done", {31'd0, frame_done}, 1);
        chk("ff_busy_fall", {31'd0, busy}, 0);
        tick(1);
        chk("ff_we_drop", {31'd0, mem_we}, 0);
        chk("ff_done_drop", {31'd0, frame_done}, 0);
        chk("ff_addr_hold", {29'd0, mem_addr}, 7);
        chk("ff_data_hold", {24'd0, mem_wdata}, 8'h17);
        chk("ff_writes", la.size(), 8);
        chk("ff_done_count", dones, 1);

        // Pre-sync discard ignores wr_gate; SOF pixel waits for the gate
        clear_log();
        wr_gate = 0;
        send(0, 8'h01); send(0, 8'h02); send(0, 8'h03); send(1, 8'hAA);
        tick(3);
        chk("ds_no_write", la.size(), 0);
        chk("ds_busy_low", {31'd0, busy}, 0);
        wr_gate = 1;
        tick(2);
        chk("ds_writes", la.size(), 1);
        chk_wr(0, 0, 8'hAA);
        chk("ds_busy_high", {31'd0, busy}, 1);

        // Backpressure: FIFO fills while gated, then drains in order without gaps
        clear_log();
        wr_gate = 0; acc = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 8) wr_gate = 1;
            s_valid = acc < 6; s_data = 8'h30 + 8'(acc);
            @(negedge clk);
            if (s_valid && s_ready) acc++;
            @(posedge clk); #1;
            if (c == 7) begin
                chk("bp_accepts", acc, 4);
                chk("bp_ready_low", {31'd0, s_ready}, 0);
                chk("bp_no_write", la.size(), 0);
            end
        end
        s_valid = 0;
        chk("bp_writes", la.size(), 6);
        for (int i = 0; i < 6; i++) chk_wr(i, 3'(i + 1), 8'h30 + 8'(i));
        chk("bp_no_gap", lc[5] - lc[0], 5);
        send(0, 8'h3F);
        tick(2);
        chk_wr(6, 7, 8'h3F);
        chk("bp_frame_done", {31'd0, lf[6]}, 1);
        chk("bp_busy_fall", {31'd0, busy}, 0);

        // Premature SOF restarts the frame at address 0
        clear_log();
        send(1, 8'h40); send(0, 8'h41); send(0, 8'h42); send(1, 8'h55); send(0, 8'h56);
        tick(3);
        chk("ps_writes", la.size(), 5);
        chk_wr(2, 2, 8'h42);
        chk_wr(3, 0, 8'h55);
        chk_wr(4, 1, 8'h56);
        chk("ps_err_on_55", {31'd0, le[3]}, 1);
        chk("ps_err_count", errs, 1);
        chk("ps_no_done", dones, 0);

        // Reset mid-frame clears outputs at once and empties the FIFO
        wr_gate = 0;
        send(0, 8'h60); send(0, 8'h61);
        rst_n = 0;
        #1;
        chk("mr_mem_we", {31'd0, mem_we}, 0);
        chk("mr_mem_addr", {29'd0, mem_addr}, 0);
        chk("mr_mem_wdata", {24'd0, mem_wdata}, 0);
        chk("mr_busy", {31'd0, busy}, 0);
        chk("mr_s_ready", {31'd0, s_ready}, 1);
        tick(2);
        rst_n = 1;
        tick(1);
        clear_log();
        send(1, 8'h70); send(0, 8'h71); send(0, 8'h72); send(0, 8'h73);
        chk("mr_full_after_4", {31'd0, s_ready}, 0);
        wr_gate = 1;
        tick(6);
        chk("mr_writes", la.size(), 4);
        for (int i = 0; i < 4; i++) chk_wr(i, 3'(i), 8'h70 + 8'(i));
        chk("mr_busy_high", {31'd0, busy}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
